// File: rtl/inst_decoder_pipe.sv
// RV32I/RV64I decode stage: field split, immediate generation and operation
// classes, followed by a CYCLE_NUM-deep valid/ready pipeline with global stall
// and flush.
// Optional feature macro: INST_DECODER_ILLEGAL_EN (adds oIllegal / oIllegalCnt).
module inst_decoder_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CYCLE_NUM = 2
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic [31:0]     iInst,
    input  logic [XLEN-1:0] iCurPC,
    input  logic            iValid,
    output logic            oReady,
    input  logic            iFlushPipe,
    input  logic            iReady,
    output logic            oValid,
    output logic [4:0]      oRs1Addr,
    output logic [4:0]      oRs2Addr,
    output logic [4:0]      oRdAddr,
    output logic [2:0]      oF3,
    output logic [6:0]      oF7,
    output logic [6:0]      oOpcode,
    output logic [XLEN-1:0] oImm,
    output logic [XLEN-1:0] oCurPc,
    output logic            oLoad,
    output logic            oStore,
    output logic            oOpImm,
    output logic            oOpPc,
    output logic            oRegDv,
`ifdef INST_DECODER_ILLEGAL_EN
    output logic            oIllegal,
    output logic [15:0]     oIllegalCnt,
`endif
    output logic [1:0]      oBrOp
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;
    localparam int unsigned BROP_W = 2;
    localparam int unsigned LAST   = CYCLE_NUM - 1;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

    localparam logic [BROP_W-1:0] BR_NONE = 2'd0;
    localparam logic [BROP_W-1:0] BR_COND = 2'd1;
    localparam logic [BROP_W-1:0] BR_JAL  = 2'd2;
    localparam logic [BROP_W-1:0] BR_JALR = 2'd3;

    if ((XLEN != 32) && (XLEN != 64)) begin : gXlenChk
        $error("inst_decoder_pipe: XLEN must be 32 or 64");
    end
    if ((CYCLE_NUM < 1) || (CYCLE_NUM > 4)) begin : gCycChk
        $error("inst_decoder_pipe: CYCLE_NUM must be 1..4");
    end

    typedef struct packed {
        logic [REG_W-1:0]  rs1Addr;
        logic [REG_W-1:0]  rs2Addr;
        logic [REG_W-1:0]  rdAddr;
        logic [F3_W-1:0]   f3;
        logic [F7_W-1:0]   f7;
        logic [OPC_W-1:0]  opcode;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   curPc;
        logic              load;
        logic              store;
        logic              opImm;
        logic              opPc;
        logic              regDv;
`ifdef INST_DECODER_ILLEGAL_EN
        logic              illegal;
`endif
        logic [BROP_W-1:0] brOp;
    } decT;

    logic [XLEN-1:0] immI, immS, immB, immU, immJ;
    decT             dec;
    decT             stgData [CYCLE_NUM];
    logic [CYCLE_NUM-1:0] stgValid;
    logic            stall;

    // Format immediates, all sign-extended from inst[31]
    assign immI = XLEN'($signed(iInst[31:20]));
    assign immS = XLEN'($signed({iInst[31:25], iInst[11:7]}));
    assign immB = XLEN'($signed({iInst[31], iInst[7], iInst[30:25], iInst[11:8], 1'b0}));
    assign immU = XLEN'($signed({iInst[31:12], 12'b0}));
    assign immJ = XLEN'($signed({iInst[31], iInst[19:12], iInst[20], iInst[30:21], 1'b0}));

    // Stage-0 decode: raw fields always pass through, classes by opcode
    always_comb begin
        dec         = '0;
        dec.rs1Addr = iInst[19:15];
        dec.rs2Addr = iInst[24:20];
        dec.rdAddr  = iInst[11:7];
        dec.f3      = iInst[14:12];
        dec.f7      = iInst[31:25];
        dec.opcode  = iInst[6:0];
        dec.curPc   = iCurPC;
`ifdef INST_DECODER_ILLEGAL_EN
        dec.illegal = 1'b0;
`endif
        case (iInst[6:0])
            OPC_LOAD:   begin dec.imm = immI; dec.load  = 1'b1; dec.opImm = 1'b1; dec.regDv = 1'b1; end
            OPC_STORE:  begin dec.imm = immS; dec.store = 1'b1; dec.opImm = 1'b1; end
            OPC_OPIMM:  begin dec.imm = immI; dec.opImm = 1'b1; dec.regDv = 1'b1; end
            OPC_OP:     begin dec.regDv = 1'b1; end
            OPC_LUI:    begin dec.imm = immU; dec.opImm = 1'b1; dec.regDv = 1'b1; end
            OPC_AUIPC:  begin dec.imm = immU; dec.opImm = 1'b1; dec.opPc = 1'b1; dec.regDv = 1'b1; end
            OPC_BRANCH: begin dec.imm = immB; dec.brOp  = BR_COND; end
            OPC_JAL:    begin dec.imm = immJ; dec.opPc  = 1'b1; dec.regDv = 1'b1; dec.brOp = BR_JAL; end
            OPC_JALR:   begin dec.imm = immI; dec.opImm = 1'b1; dec.regDv = 1'b1; dec.brOp = BR_JALR; end
            default: begin
`ifdef INST_DECODER_ILLEGAL_EN
                dec.illegal = 1'b1;
`endif
            end
        endcase
`ifdef INST_DECODER_ILLEGAL_EN
        // Compressed-space encodings and bad OP funct7/funct3 combinations
        if (iInst[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end
        if (iInst[6:0] == OPC_OP) begin
            if ((iInst[31:25] != 7'b0000000) && (iInst[31:25] != 7'b0100000)) begin
                dec.illegal = 1'b1;
            end
            if ((iInst[31:25] == 7'b0100000) && (iInst[14:12] != 3'b000) && (iInst[14:12] != 3'b101)) begin
                dec.illegal = 1'b1;
            end
        end
`endif
    end

    // Global stall when the head cannot leave; flush always frees the input
    assign stall  = stgValid[LAST] & ~iReady;
    assign oReady = iFlushPipe | ~stall;

    // Pipeline registers: flush clears valids, stall holds everything
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            stgValid <= '0;
            for (int unsigned i = 0; i < CYCLE_NUM; i++) begin
                stgData[i] <= '0;
            end
        end else if (iFlushPipe) begin
            stgValid <= '0;
        end else if (!stall) begin
            stgValid[0] <= iValid;
            stgData[0]  <= dec;
            for (int unsigned i = 1; i < CYCLE_NUM; i++) begin
                stgValid[i] <= stgValid[i-1];
                stgData[i]  <= stgData[i-1];
            end
        end
    end

    assign oValid   = stgValid[LAST];
    assign oRs1Addr = stgData[LAST].rs1Addr;
    assign oRs2Addr = stgData[LAST].rs2Addr;
    assign oRdAddr  = stgData[LAST].rdAddr;
    assign oF3      = stgData[LAST].f3;
    assign oF7      = stgData[LAST].f7;
    assign oOpcode  = stgData[LAST].opcode;
    assign oImm     = stgData[LAST].imm;
    assign oCurPc   = stgData[LAST].curPc;
    assign oLoad    = stgData[LAST].load;
    assign oStore   = stgData[LAST].store;
    assign oOpImm   = stgData[LAST].opImm;
    assign oOpPc    = stgData[LAST].opPc;
    assign oRegDv   = stgData[LAST].regDv;
    assign oBrOp    = stgData[LAST].brOp;

`ifdef INST_DECODER_ILLEGAL_EN
    assign oIllegal = stgData[LAST].illegal;

    // Saturating count of illegal instructions handed to execute
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oIllegalCnt <= '0;
        end else if (oValid && iReady && oIllegal && (oIllegalCnt != 16'hFFFF)) begin
            oIllegalCnt <= oIllegalCnt + 16'd1;
        end
    end
`endif

endmodule
